// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the program-memory arbiter and its fetch buffer.
package prog_mem_pkg;

    localparam int WORD_AW = 9;   // SRAM word address width (512 words)
    localparam int BYTE_AW = 11;  // CPU byte address width
    localparam int DW      = 32;  // SRAM data width

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        WB_RD,
        WB_ACK
    } state_e;

    // Little-endian byte lane of a 32-bit word.
    function automatic logic [7:0] lane_byte(input logic [DW-1:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/prog_fetch_buf.sv
// One-word CPU fetch buffer: tag/valid/data, hit compare, lane select and a
// Wishbone write-merge port that keeps the buffered word coherent with SRAM.
module prog_fetch_buf
    import prog_mem_pkg::*;
(
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [WORD_AW-1:0] lookup_word,
    input  logic [1:0]         lookup_lane,
    output logic               hit,
    output logic [7:0]         hit_byte,
    input  logic               load_en,
    input  logic [WORD_AW-1:0] load_word,
    input  logic [DW-1:0]      load_data,
    input  logic               wr_en,
    input  logic [WORD_AW-1:0] wr_word,
    input  logic [3:0]         wr_sel,
    input  logic [DW-1:0]      wr_data
);

    logic               buf_valid;
    logic [WORD_AW-1:0] buf_tag;
    logic [DW-1:0]      buf_data;
    logic               wr_hit;
    logic [DW-1:0]      merged;

    assign hit      = buf_valid && (buf_tag == lookup_word);
    assign hit_byte = lane_byte(buf_data, lookup_lane);
    assign wr_hit   = wr_en && buf_valid && (buf_tag == wr_word);

    // Byte-enable merge of a Wishbone write into the buffered word.
    always_comb begin
        // NOTE: a default assignment before any conditional keeps always_comb from inferring a latch.
        merged = buf_data;
        for (int b = 0; b < 4; b++) begin
            if (wr_sel[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    // Tag and valid: invalidated by reset, set by a CPU miss fill.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
        end else if (load_en) begin
            buf_valid <= 1'b1;
            buf_tag   <= load_word;
        end
    end

    // Data word: filled on a miss, byte-merged on a matching Wishbone write.
    // NOTE: buf_data has no reset; buf_valid qualifies every use, so a reset here would only cost area.
    always_ff @(posedge wb_clk_i) begin
        if (load_en) begin
            buf_data <= load_data;
        end else if (wr_hit) begin
            buf_data <= merged;
        end
    end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Shares the single-port program SRAM between the CPU byte fetch (through a
// one-word buffer) and the Wishbone host, with a starvation bound for the host.
module prog_mem_arbiter
    import prog_mem_pkg::*;
#(
    parameter int SEL_BIT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               cpu_req_i,
    input  logic [BYTE_AW-1:0] cpu_addr_i,
    output logic               cpu_rdy_o,
    output logic [7:0]         cpu_data_o,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [DW-1:0]      wbs_dat_i,
    output logic [DW-1:0]      wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               sram_csb_o,
    output logic               sram_web_o,
    output logic [3:0]         sram_wmask_o,
    output logic [WORD_AW-1:0] sram_addr_o,
    output logic [DW-1:0]      sram_din_o,
    input  logic [DW-1:0]      sram_dout_i,
    output logic               wb_starved_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_e             state;
    logic [CW-1:0]      starve_cnt;
    logic [WORD_AW-1:0] cpu_word_q;
    logic [1:0]         cpu_lane_q;

    logic               wb_valid;
    logic [WORD_AW-1:0] wb_word;
    logic [WORD_AW-1:0] cpu_word;
    logic               cpu_hit;
    logic [7:0]         cpu_hit_byte;
    logic               cpu_miss;
    logic               in_idle;
    logic               wb_grant;
    logic               cpu_grant;
    logic               cpu_hit_serve;
    logic               unused_adr;

    assign wb_valid      = wbs_cyc_i && wbs_stb_i && wbs_adr_i[SEL_BIT];
    assign wb_word       = wbs_adr_i[WORD_AW+1:2];
    assign cpu_word      = cpu_addr_i[BYTE_AW-1:2];
    assign cpu_miss      = cpu_req_i && !cpu_hit;
    assign wb_starved_o  = (starve_cnt == CW'(STARVE_LIMIT));
    // Grants are suppressed while reset is held so the SRAM stays deselected.
    assign in_idle       = wb_rst_ni && (state == IDLE);
    assign wb_grant      = in_idle && wb_valid && !wbs_ack_o && (!cpu_miss || wb_starved_o);
    // A request seen in the cycle of its own rdy pulse is the old one and is not taken.
    assign cpu_grant     = in_idle && cpu_miss && !cpu_rdy_o && !wb_grant;
    assign cpu_hit_serve = in_idle && cpu_req_i && cpu_hit && !cpu_rdy_o;
    assign unused_adr    = ^wbs_adr_i;

    prog_fetch_buf u_fetch_buf (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .lookup_word (cpu_word),
        .lookup_lane (cpu_addr_i[1:0]),
        .hit         (cpu_hit),
        .hit_byte    (cpu_hit_byte),
        .load_en     (state == CPU_RD),
        .load_word   (cpu_word_q),
        .load_data   (sram_dout_i),
        .wr_en       (wb_grant && wbs_we_i),
        .wr_word     (wb_word),
        .wr_sel      (wbs_sel_i),
        .wr_data     (wbs_dat_i)
    );

    // SRAM port is driven only in the cycle an access is granted.
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = 4'b0000;
        sram_addr_o  = '0;
        sram_din_o   = '0;
        if (wb_grant) begin
            sram_csb_o  = 1'b0;
            sram_addr_o = wb_word;
            if (wbs_we_i) begin
                sram_web_o   = 1'b0;
                sram_wmask_o = wbs_sel_i;
                sram_din_o   = wbs_dat_i;
            end
        end else if (cpu_grant) begin
            sram_csb_o  = 1'b0;
            sram_addr_o = cpu_word;
        end
    end

    // Access FSM with starvation counter and registered responses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cpu_word_q <= '0;
            cpu_lane_q <= '0;
            cpu_rdy_o  <= 1'b0;
            cpu_data_o <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cpu_rdy_o <= 1'b0;
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_hit_serve) begin
                        cpu_rdy_o  <= 1'b1;
                        cpu_data_o <= cpu_hit_byte;
                    end
                    if (wb_grant) begin
                        starve_cnt <= '0;
                        if (wbs_we_i) begin
                            wbs_ack_o <= 1'b1;
                            state     <= WB_ACK;
                        end else begin
                            state <= WB_RD;
                        end
                    end else begin
                        if (wb_valid && !wb_starved_o) starve_cnt <= starve_cnt + CW'(1);
                        if (cpu_grant) begin
                            cpu_word_q <= cpu_word;
                            cpu_lane_q <= cpu_addr_i[1:0];
                            state      <= CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    cpu_rdy_o  <= 1'b1;
                    cpu_data_o <= lane_byte(sram_dout_i, cpu_lane_q);
                    state      <= IDLE;
                end
                WB_RD: begin
                    wbs_dat_o <= sram_dout_i;
                    wbs_ack_o <= 1'b1;
                    state     <= WB_ACK;
                end
                WB_ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
